// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register target.
// Command byte layout, FSM states and the out-of-range read value.
package spi_reg_pkg;

    localparam int RW_BIT = 7;
    localparam int ADDR_W = 7;

    localparam logic [7:0] READ_OOR_VAL = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_e;

endpackage

// File: rtl/spi_reg_target_if.sv
// SPI pad bundle between an external controller and the register target.
interface spi_reg_target_if;

    logic spi_csn_i;
    logic spi_sclk_i;
    logic spi_mosi_i;
    logic spi_miso_o;
    logic spi_miso_oe_o;

    modport master (
        output spi_csn_i,
        output spi_sclk_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  spi_miso_oe_o
    );

    modport slave (
        input  spi_csn_i,
        input  spi_sclk_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output spi_miso_oe_o
    );

endinterface

// File: rtl/spi_reg_sync.sv
// Multi-flop synchroniser for one asynchronous pad input,
// with optional rise/fall detection on the synchronised level.
module spi_reg_sync #(
    parameter int STAGES   = 2,
    parameter bit IDLE_VAL = 1'b0,
    parameter bit EDGES    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = EDGES & q_o & ~prev_q;
    assign fall_o = EDGES & ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing a byte-wide register bank, fully
// oversampled on wb_clk_i; command byte {rw, addr[6:0]} then burst data.
module spi_reg_target
    import spi_reg_pkg::*;
#(
    parameter int         NREGS       = 8,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    spi_reg_target_if.slave    spi,
    output logic [NREGS*8-1:0] regs_o,
    output logic               wr_strobe_o,
    output logic [6:0]         wr_addr_o,
    output logic [7:0]         wr_data_o
);

    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES + 1);

    logic csn_s, csn_rise, csn_fall;
    logic sclk_rise, sclk_fall, mosi_s;
    logic unused_sclk, unused_mosi_rise, unused_mosi_fall;

    spi_reg_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1), .EDGES(1'b1)) u_csn (
        .clk(wb_clk_i), .rst(wb_rst_i), .d_i(spi.spi_csn_i),
        .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
    );

    spi_reg_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0), .EDGES(1'b1)) u_sclk (
        .clk(wb_clk_i), .rst(wb_rst_i), .d_i(spi.spi_sclk_i),
        .q_o(unused_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_reg_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0), .EDGES(1'b0)) u_mosi (
        .clk(wb_clk_i), .rst(wb_rst_i), .d_i(spi.spi_mosi_i),
        .q_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [6:0]         rx_q, rx_d;
    logic [6:0]         tx_q, tx_d;
    logic               rw_q, rw_d;
    logic [6:0]         addr_q, addr_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic [NREGS*8-1:0] regs_q, regs_d;
    logic               stb_q, stb_d;
    logic [6:0]         wa_q, wa_d;
    logic [7:0]         wd_q, wd_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic               armed_q, armed_d;

    logic [7:0] rx_byte, rd_val;
    logic [6:0] addr_inc, rd_addr;
    logic       byte_done, wr_hit;

    assign rx_byte   = {rx_q, mosi_s};
    assign addr_inc  = addr_q + 7'd1;
    assign byte_done = sclk_rise & (cnt_q == 3'd7);
    assign rd_addr   = (state_q == CMD) ? rx_byte[ADDR_W-1:0] : addr_inc;

    always_comb begin
        rd_val = READ_OOR_VAL;
        for (int k = 0; k < NREGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_val = regs_q[8*k +: 8];
        end
    end

    // A frame only starts once csn has been seen high on real pad data,
    // so a reset in mid-frame ignores the rest of that frame.
    always_comb begin
        settle_d = (settle_q == SETTLED) ? settle_q : settle_q + SW'(1);
        armed_d  = armed_q | ((settle_q == SETTLED) & csn_s);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        regs_d  = regs_q;
        stb_d   = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wr_hit  = 1'b0;
        if (csn_fall && armed_q) begin
            state_d = CMD;
            cnt_d   = 3'd0;
            oe_d    = 1'b1;
            miso_d  = 1'b0;
            tx_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    oe_d   = 1'b0;
                    miso_d = 1'b0;
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        rw_d    = rx_byte[RW_BIT];
                        addr_d  = rx_byte[ADDR_W-1:0];
                        state_d = DATA;
                        tx_d    = rx_byte[RW_BIT] ? rd_val[6:0] : 7'd0;
                        miso_d  = rx_byte[RW_BIT] & rd_val[7];
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        if (!rw_q) begin
                            for (int k = 0; k < NREGS; k++) begin
                                if (addr_q == ADDR_W'(k)) begin
                                    regs_d[8*k +: 8] = rx_byte;
                                    wr_hit           = 1'b1;
                                end
                            end
                        end
                        stb_d  = wr_hit;
                        wa_d   = wr_hit ? addr_q : wa_q;
                        wd_d   = wr_hit ? rx_byte : wd_q;
                        addr_d = addr_inc;
                        tx_d   = rw_q ? rd_val[6:0] : 7'd0;
                        miso_d = rw_q & rd_val[7];
                    end else if (sclk_fall && rw_q && cnt_q != 3'd0) begin
                        // The fall that ends a byte keeps the freshly loaded MSB.
                        tx_d   = {tx_q[5:0], 1'b0};
                        miso_d = tx_q[6];
                    end
                end
                default: state_d = IDLE;
            endcase
            if (csn_rise) begin
                state_d = IDLE;
                cnt_d   = 3'd0;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            rx_q     <= 7'd0;
            tx_q     <= 7'd0;
            rw_q     <= 1'b0;
            addr_q   <= 7'd0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            regs_q   <= {NREGS{RESET_VAL}};
            stb_q    <= 1'b0;
            wa_q     <= 7'd0;
            wd_q     <= 8'd0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            regs_q   <= regs_d;
            stb_q    <= stb_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    assign spi.spi_miso_o    = miso_q;
    assign spi.spi_miso_oe_o = oe_q;
    assign regs_o            = regs_q;
    assign wr_strobe_o       = stb_q;
    assign wr_addr_o         = wa_q;
    assign wr_data_o         = wd_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: two instances (8 and 128 registers)
// driven by a bit-level SPI controller, checked against a register-array model.
module tb_spi_reg_target;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic csn  = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    bit   sel  = 1'b0;

    spi_reg_target_if ifa ();
    spi_reg_target_if ifb ();

    assign ifa.spi_csn_i  = sel ? 1'b1 : csn;
    assign ifa.spi_sclk_i = sclk;
    assign ifa.spi_mosi_i = mosi;
    assign ifb.spi_csn_i  = sel ? csn : 1'b1;
    assign ifb.spi_sclk_i = sclk;
    assign ifb.spi_mosi_i = mosi;

    wire miso = sel ? ifb.spi_miso_o : ifa.spi_miso_o;
    wire oe   = sel ? ifb.spi_miso_oe_o : ifa.spi_miso_oe_o;

    logic [63:0]   regs_a;
    logic [1023:0] regs_b;
    logic          stb_a, stb_b;
    logic [6:0]    wa_a, wa_b;
    logic [7:0]    wd_a, wd_b;

    spi_reg_target #(.NREGS(8), .RESET_VAL(8'h00), .SYNC_STAGES(2)) ua (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi(ifa.slave),
        .regs_o(regs_a), .wr_strobe_o(stb_a), .wr_addr_o(wa_a), .wr_data_o(wd_a)
    );

    spi_reg_target #(.NREGS(128), .RESET_VAL(8'h00), .SYNC_STAGES(2)) ub (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi(ifb.slave),
        .regs_o(regs_b), .wr_strobe_o(stb_b), .wr_addr_o(wa_b), .wr_data_o(wd_b)
    );

    int total = 0;
    int bad   = 0;
    int stb_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (stb_a) stb_cnt[0]++;
        if (stb_b) stb_cnt[1]++;
    end

    logic [7:0] mdl [2][128];
    logic [6:0] mla [2];
    logic [7:0] mld [2];

    typedef struct {
        bit          b;
        logic [7:0]  cmd;
        int          n;
        logic [23:0] d;
        logic [23:0] e;
        int          ns;
        logic [6:0]  la;
        logic [7:0]  ld;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, input bit cs_end,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            clks(8);
            rx[7-i] = miso;
            sclk = 1'b1;
            if (cs_end && i == nb - 1) csn = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input bit b, input logic [7:0] cmd, input int n,
                         input logic [23:0] din, output logic [23:0] dout,
                         output int nstb);
        int s0;
        logic [7:0] r;
        sel  = b;
        s0   = stb_cnt[b];
        dout = '0;
        clks(4);
        csn = 1'b0;
        clks(8);
        spi_bits(cmd, 8, 1'b0, r);
        chk("miso_in_cmd", r, 0);
        chk("oe_on", oe, 1);
        for (int i = 0; i < n; i++) begin
            spi_bits(din[23-8*i -: 8], 8, 1'b0, r);
            dout[23-8*i -: 8] = r;
        end
        clks(8);
        csn = 1'b1;
        clks(24);
        chk("oe_off", oe, 0);
        nstb = stb_cnt[b] - s0;
    endtask

    task automatic model(input bit b, input logic [7:0] cmd, input int n,
                         input logic [23:0] din, output logic [23:0] exp,
                         output int nstb);
        logic [6:0] a;
        logic [7:0] v;
        int lim;
        a    = cmd[6:0];
        exp  = '0;
        nstb = 0;
        lim  = b ? 128 : 8;
        for (int i = 0; i < n; i++) begin
            v = din[23-8*i -: 8];
            if (cmd[7]) begin
                exp[23-8*i -: 8] = (int'(a) < lim) ? mdl[b][a] : 8'h00;
            end else if (int'(a) < lim) begin
                mdl[b][a] = v;
                mla[b]    = a;
                mld[b]    = v;
                nstb++;
            end
            a = a + 7'd1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 128; k++) mdl[i][k] = 8'h00;
            mla[i] = 7'd0;
            mld[i] = 8'd0;
        end
    endtask

    task automatic reg_check(input string nm);
        for (int k = 0; k < 8; k++)   chk({nm, "_regA"}, regs_a[8*k +: 8], mdl[0][k]);
        for (int k = 0; k < 128; k++) chk({nm, "_regB"}, regs_b[8*k +: 8], mdl[1][k]);
    endtask

    task automatic last_check(input bit b);
        chk("wr_addr", b ? wa_b : wa_a, mla[b]);
        chk("wr_data", b ? wd_b : wd_a, mld[b]);
    endtask

    logic [23:0] dout, e;
    logic [7:0]  r, rdat;
    logic [7:0]  cmd;
    logic [23:0] din;
    int          ns, ens, s0, n;
    bit          b;

    initial begin
        tbl[0] = '{1'b0, 8'h03, 1, 24'hA50000, 24'h000000, 1, 7'd3, 8'hA5};
        tbl[1] = '{1'b0, 8'h06, 2, 24'h112200, 24'h000000, 2, 7'd7, 8'h22};
        tbl[2] = '{1'b0, 8'h86, 3, 24'h000000, 24'h112200, 0, 7'd7, 8'h22};
        tbl[3] = '{1'b1, 8'h7F, 2, 24'hC33C00, 24'h000000, 2, 7'd0, 8'h3C};
        tbl[4] = '{1'b1, 8'hFF, 2, 24'h000000, 24'hC33C00, 0, 7'd0, 8'h3C};
        tbl[5] = '{1'b0, 8'h83, 1, 24'h000000, 24'hA50000, 0, 7'd7, 8'h22};
        tbl[6] = '{1'b0, 8'h0A, 1, 24'h550000, 24'h000000, 0, 7'd7, 8'h22};

        model_reset();
        rst = 1'b1;
        clks(4);
        rst = 1'b0;
        clks(10);

        reg_check("reset");
        chk("reset_oe_a", ifa.spi_miso_oe_o, 0);
        chk("reset_oe_b", ifb.spi_miso_oe_o, 0);
        chk("reset_miso_a", ifa.spi_miso_o, 0);
        chk("reset_stb", stb_cnt[0] + stb_cnt[1], 0);
        last_check(1'b0);
        last_check(1'b1);

        for (int i = 0; i < 7; i++) begin
            model(tbl[i].b, tbl[i].cmd, tbl[i].n, tbl[i].d, e, ens);
            frame(tbl[i].b, tbl[i].cmd, tbl[i].n, tbl[i].d, dout, ns);
            chk($sformatf("vec%0d_miso", i), dout, tbl[i].e);
            chk($sformatf("vec%0d_strobes", i), ns, tbl[i].ns);
            chk($sformatf("vec%0d_wr_addr", i), tbl[i].b ? wa_b : wa_a, tbl[i].la);
            chk($sformatf("vec%0d_wr_data", i), tbl[i].b ? wd_b : wd_a, tbl[i].ld);
        end
        chk("wrap_reg127", regs_b[1023:1016], 8'hC3);
        chk("wrap_reg0", regs_b[7:0], 8'h3C);
        reg_check("table");

        // partial byte then csn high: nothing committed
        sel = 1'b0;
        s0  = stb_cnt[0];
        clks(4);
        csn = 1'b0;
        clks(8);
        spi_bits(8'h01, 8, 1'b0, r);
        spi_bits(8'hFF, 5, 1'b0, r);
        clks(8);
        csn = 1'b1;
        clks(24);
        chk("abort_strobes", stb_cnt[0] - s0, 0);
        chk("abort_reg1", regs_a[15:8], mdl[0][1]);
        model(1'b0, 8'h01, 1, 24'h5A0000, e, ens);
        frame(1'b0, 8'h01, 1, 24'h5A0000, dout, ns);
        chk("after_abort_strobes", ns, 1);
        chk("after_abort_reg1", regs_a[15:8], 8'h5A);
        last_check(1'b0);

        // 8th rise and csn rise on the same pad edge: byte still commits
        sel = 1'b0;
        s0  = stb_cnt[0];
        clks(4);
        csn = 1'b0;
        clks(8);
        spi_bits(8'h04, 8, 1'b0, r);
        spi_bits(8'h9C, 8, 1'b1, r);
        clks(24);
        model(1'b0, 8'h04, 1, 24'h9C0000, e, ens);
        chk("cs_edge_strobes", stb_cnt[0] - s0, 1);
        chk("cs_edge_reg4", regs_a[39:32], 8'h9C);
        last_check(1'b0);

        // reset between command and data byte
        sel = 1'b0;
        s0  = stb_cnt[0];
        clks(4);
        csn = 1'b0;
        clks(8);
        spi_bits(8'h02, 8, 1'b0, r);
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        model_reset();
        spi_bits(8'h77, 8, 1'b0, r);
        clks(8);
        csn = 1'b1;
        clks(24);
        chk("rst_mid_strobes", stb_cnt[0] - s0, 0);
        last_check(1'b0);
        reg_check("rst_mid");
        model(1'b0, 8'h02, 1, 24'h770000, e, ens);
        frame(1'b0, 8'h02, 1, 24'h770000, dout, ns);
        chk("after_rst_strobes", ns, 1);
        chk("after_rst_reg2", regs_a[23:16], 8'h77);
        last_check(1'b0);

        for (int i = 0; i < 24; i++) begin
            b   = 1'($urandom_range(0, 1));
            cmd = {1'($urandom_range(0, 1)),
                   b ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 11))};
            n   = $urandom_range(1, 3);
            din = 24'($urandom());
            model(b, cmd, n, din, e, ens);
            frame(b, cmd, n, din, dout, ns);
            chk($sformatf("rnd%0d_miso", i), dout, e);
            chk($sformatf("rnd%0d_strobes", i), ns, ens);
            last_check(b);
        end
        reg_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI target (responder) in the user area: the external SPI controller reads and writes a small byte-wide register bank over the pads.
- All logic runs on the Wishbone clock. SCLK, CSn and MOSI are oversampled and synchronised; the target never clocks on SCLK.
- The register bank is exported as a flat bus to user logic. A per-write strobe reports each register update.

Parameters:
- NREGS, 8, number of 8-bit registers; legal range 1..128.
- RESET_VAL, 8'h00, reset value of every register.
- SYNC_STAGES, 2, synchroniser depth on spi_csn_i, spi_sclk_i and spi_mosi_i; minimum 2.

Ports:
- wb_clk_i  input  1  system clock; SCLK must be at most wb_clk_i/8.
- wb_rst_i  input  1  reset, synchronous, active-high.
- spi_csn_i  input  1  chip select, active-low, asynchronous to wb_clk_i.
- spi_sclk_i  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_mosi_i  input  1  controller-to-target data, MSB first.
- spi_miso_o  output  1  target-to-controller data, MSB first.
- spi_miso_oe_o  output  1  pad output enable for MISO; 1 only while selected.
- regs_o  output  NREGS*8  register bank; register k is at bits [8k+7:8k].
- wr_strobe_o  output  1  one-cycle pulse on every register update.
- wr_addr_o  output  7  address of the last write.
- wr_data_o  output  8  data of the last write.

Behaviour:
- Reset values:
  - regs_o: all registers = RESET_VAL.
  - spi_miso_o = 0, spi_miso_oe_o = 0.
  - wr_strobe_o = 0, wr_addr_o = 0, wr_data_o = 0.
  - FSM in IDLE, bit counter = 0, synchroniser flops = idle levels (csn = 1, sclk = 0).
- Synchronisation:
  - Each SPI input passes through SYNC_STAGES flops.
  - An SCLK edge is detected when the last synchronised sample differs from the previous one.
  - Pin-to-detect latency is SYNC_STAGES+1 clocks.
- Byte framing:
  - MOSI is sampled into an 8-bit shift register on each detected SCLK rise.
  - A 3-bit counter counts those rises; a byte is complete on the 8th rise.
- FSM states:
  - IDLE: csn high. MISO output disabled. Leave IDLE on a detected csn fall; go to CMD with counter = 0.
  - CMD: on byte completion, latch rw = bit7 (1 = read) and addr = bits[6:0], then go to DATA.
    - If read, load the tx shifter with the addressed register and drive its MSB on spi_miso_o in the next clock.
  - DATA, write: on byte completion, if addr < NREGS, write the byte into that register. One clock after the 8th detected rise, pulse wr_strobe_o and update wr_addr_o/wr_data_o; regs_o changes in the same clock.
  - DATA, read: on every detected SCLK fall the tx shifter shifts left and spi_miso_o takes the new MSB. The first data bit is already driven before the first rise of the byte.
  - End of a DATA byte, either direction: addr auto-increments modulo 128 and the FSM stays in DATA (burst). A read reloads the tx shifter from the new address.
- Out-of-range addresses (addr >= NREGS): writes are ignored and produce no strobe; reads return 8'h00.
- spi_miso_o = 0 whenever no read byte is in progress, including during CMD.
- spi_miso_oe_o = 1 from the detected csn fall until the detected csn rise.
- csn rise at any point:
  - Return to IDLE next clock; a partial byte is discarded, with no write and no strobe.
  - A byte whose 8th rise coincides with the csn rise is still committed.
- csn fall while not in IDLE (glitch): restart in CMD with counter = 0.
- wb_rst_i asserted mid-transaction: every state returns to its reset value. The rest of that CS frame is ignored until csn is seen high and then low again.
- Simultaneous events: a user-visible write and a tx load of the same register in one clock is impossible, because a frame is either read or write. Writes have no user-side contention; only SPI writes the bank.

Decomposition:
- Package spi_reg_pkg:
  - Command-byte field constants: RW bit = 7, ADDR_W = 7.
  - FSM state enum {IDLE, CMD, DATA}.
  - Constant READ_OOR_VAL = 8'h00.
- Sub-module spi_reg_sync: parameterised SYNC_STAGES-deep synchroniser plus rise/fall edge detector, instantiated for sclk and csn (and for mosi without edge outputs).

Test Plan:
- Reset check: after wb_rst_i, regs_o = all RESET_VAL, spi_miso_oe_o = 0, wr_strobe_o never pulses.
- Single write: cmd 8'h03, data 8'hA5 (NREGS = 8) -> one wr_strobe_o, wr_addr_o = 3, wr_data_o = 8'hA5, regs_o[31:24] = 8'hA5, all other registers unchanged.
- Burst read: preload registers 6 = 8'h11, 7 = 8'h22; send cmd 8'h86 then three data bytes -> MISO returns 8'h11, 8'h22, 8'h00 (address 8 is out of range).
- Aborted frame: cmd 8'h01 plus 5 data bits, then csn high -> no strobe, register 1 unchanged; the next full write to address 1 succeeds.
- Wrap and out-of-range: NREGS = 128, write burst starting at 8'h7F with data 8'hC3, 8'h3C -> register 127 = 8'hC3, then register 0 = 8'h3C with two strobes.
- Reset mid-frame: assert wb_rst_i after the cmd byte of a write -> no strobe, bank back to RESET_VAL, remaining frame bits ignored; the next frame works normally.
